// File: rtl/sb_tx_serializer_if.sv
// FIFO-side bus of the sideband TX serializer.
// The master modport is the serializer, which pops the FIFO. The slave modport is the FIFO.
interface sb_tx_serializer_if #(
  parameter int WIDTH = 64
);
  logic             i_fifo_empty;
  logic [WIDTH-1:0] i_fifo_data;
  logic             i_dont_send_zeros;
  logic             o_fifo_read_enable;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_dont_send_zeros,
    output o_fifo_read_enable
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    output i_dont_send_zeros,
    input  o_fifo_read_enable
  );
endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer.
// Pops one word from the TX FIFO and drops all-zero filler words.
// Shifts each real word out LSB-first with a matching clock enable.
// Then holds the lane low for GAP_UI cycles before the next packet.
module sb_tx_serializer #(
  parameter int WIDTH  = 64,
  parameter int GAP_UI = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  sb_tx_serializer_if.master  fifo_if,
  output logic                o_txdata_sb,
  output logic                o_txclk_en,
  output logic                o_busy,
  output logic                o_packet_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [6:0] LAST_BIT = 7'(WIDTH - 1);
  localparam logic [6:0] LAST_GAP = 7'(GAP_UI - 1);

  state_t           r_state;
  logic [6:0]       r_bit_cnt;
  logic [WIDTH-1:0] r_sr;
  logic             r_txdata;
  logic             r_txclk_en;
  logic             r_busy;
  logic             r_packet_done;

  state_t           w_next_state;
  logic [6:0]       w_next_cnt;
  logic [WIDTH-1:0] w_next_sr;
  logic             w_read_en;

  // Next-state, counter and shift-register update; the pop strobe is only ever raised from IDLE
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_bit_cnt;
    w_next_sr    = r_sr;
    w_read_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable && !fifo_if.i_fifo_empty) begin
          w_read_en    = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        if (fifo_if.i_dont_send_zeros) begin
          w_next_state = IDLE;
        end else begin
          w_next_sr    = fifo_if.i_fifo_data;
          w_next_cnt   = 7'd0;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        w_next_sr = r_sr >> 1;
        if (r_bit_cnt == LAST_BIT) begin
          w_next_cnt   = 7'd0;
          w_next_state = GAP;
        end else begin
          w_next_cnt = r_bit_cnt + 7'd1;
        end
      end
      GAP: begin
        if (r_bit_cnt == LAST_GAP) begin
          w_next_cnt   = 7'd0;
          w_next_state = IDLE;
        end else begin
          w_next_cnt = r_bit_cnt + 7'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, counter and shift register; outputs are registered from next-state so they line up with SHIFT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_bit_cnt     <= 7'd0;
      r_sr          <= '0;
      r_txdata      <= 1'b0;
      r_txclk_en    <= 1'b0;
      r_busy        <= 1'b0;
      r_packet_done <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_bit_cnt     <= w_next_cnt;
      r_sr          <= w_next_sr;
      r_txdata      <= (w_next_state == SHIFT) && w_next_sr[0];
      r_txclk_en    <= (w_next_state == SHIFT);
      r_busy        <= (w_next_state != IDLE);
      r_packet_done <= (r_state == SHIFT) && (w_next_state == GAP);
    end
  end

  // The strobe is gated by reset so that no pop can leak out while reset is held
  assign fifo_if.o_fifo_read_enable = w_read_en && i_rst_n;
  assign o_txdata_sb                = r_txdata;
  assign o_txclk_en                 = r_txclk_en;
  assign o_busy                     = r_busy;
  assign o_packet_done              = r_packet_done;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Testbench for sb_tx_serializer.
// A queue-based FIFO feeds the DUT. A packet-timeline reference model predicts every output each cycle.
module tb_sb_tx_serializer;

  localparam int W = 64;
  localparam int G = 32;

  logic clk = 1'b0;
  logic rstN;
  logic enable;
  logic txData;
  logic txClkEn;
  logic busy;
  logic packetDone;

  sb_tx_serializer_if #(.WIDTH(W)) fifoIf ();

  sb_tx_serializer #(.WIDTH(W), .GAP_UI(G)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_enable      (enable),
    .fifo_if       (fifoIf.master),
    .o_txdata_sb   (txData),
    .o_txclk_en    (txClkEn),
    .o_busy        (busy),
    .o_packet_done (packetDone)
  );

  // Free-running bit clock
  always #5 clk = ~clk;

  logic [W-1:0] fifoQ[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: the most recent packet's start cycle, its word, and when the link frees up
  bit           mStarted;
  bit           mPkt;
  int           mStart;
  int           mFree;
  logic [W-1:0] mWord;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] word);
    fifoQ.push_back(word);
    fifoIf.i_fifo_empty = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd"},   64'(fifoIf.o_fifo_read_enable), 64'd0);
    checkOutput({tag, "_data"}, 64'(txData),     64'd0);
    checkOutput({tag, "_clken"},64'(txClkEn),    64'd0);
    checkOutput({tag, "_busy"}, 64'(busy),       64'd0);
    checkOutput({tag, "_done"}, 64'(packetDone), 64'd0);
  endtask

  // One clock cycle: predict and compare at the negedge, then advance the FIFO just after the posedge
  task automatic runCycles(input int n);
    bit expRd, expEn, expData, expDone, expBusy, sawRd;
    int d;
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      expRd = (cyc >= mFree) && enable && (fifoQ.size() > 0);
      if (expRd) begin
        mStarted = 1'b1;
        mStart   = cyc;
        mWord    = fifoQ[0];
        mPkt     = (fifoQ[0] != '0);
        mFree    = mPkt ? cyc + W + G + 2 : cyc + 2;
      end
      d       = cyc - mStart;
      expEn   = mStarted && mPkt && (d >= 2) && (d <= W + 1);
      expData = expEn ? mWord[d-2] : 1'b0;
      expDone = mStarted && mPkt && (d == W + 2);
      expBusy = mStarted && (d >= 1) && (cyc < mFree);
      checkOutput("rd",    64'(fifoIf.o_fifo_read_enable), 64'(expRd));
      checkOutput("data",  64'(txData),     64'(expData));
      checkOutput("clken", 64'(txClkEn),    64'(expEn));
      checkOutput("busy",  64'(busy),       64'(expBusy));
      checkOutput("done",  64'(packetDone), 64'(expDone));
      sawRd = fifoIf.o_fifo_read_enable;
      @(posedge clk);
      #1;
      if (sawRd && fifoQ.size() > 0) begin
        w = fifoQ.pop_front();
        fifoIf.i_fifo_data       = w;
        fifoIf.i_dont_send_zeros = (w == '0);
      end
      fifoIf.i_fifo_empty = (fifoQ.size() == 0);
      cyc++;
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must drop at once
  task automatic pulseReset(input string tag);
    rstN = 1'b0;
    #1;
    checkAllZero(tag);
    mStarted = 1'b0;
    mPkt     = 1'b0;
    mFree    = cyc;
    #1;
    rstN = 1'b1;
  endtask

  // Directed scenarios followed by a randomized phase
  initial begin
    logic [W-1:0] rw;
    rstN                     = 1'b0;
    enable                   = 1'b0;
    fifoIf.i_fifo_empty      = 1'b1;
    fifoIf.i_fifo_data       = '0;
    fifoIf.i_dont_send_zeros = 1'b0;
    mStarted = 1'b0;
    mPkt     = 1'b0;
    mStart   = 0;
    mFree    = 0;
    mWord    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rstN   = 1'b1;
    enable = 1'b1;

    applyStimulus(64'h8000_0000_0000_0001);
    runCycles(110);

    applyStimulus(64'hA5A5_0000_FFFF_1234);
    applyStimulus(64'h0123_4567_89AB_CDEF);
    runCycles(210);

    applyStimulus(64'h0);
    applyStimulus(64'h1);
    runCycles(110);

    runCycles(200);

    applyStimulus(64'hDEAD_BEEF_CAFE_F00D);
    runCycles(12);
    enable = 1'b0;
    applyStimulus(64'h1357_9BDF_2468_ACE0);
    runCycles(200);
    enable = 1'b1;
    runCycles(110);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'h0F0F_0F0F_F0F0_F0F0);
    runCycles(32);
    pulseReset("midreset");
    runCycles(110);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rw = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
        applyStimulus(rw);
      end
      if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) pulseReset("rndreset");
      runCycles(1);
    end
    enable = 1'b1;
    runCycles(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
